// File: rtl/edge_event_monitor.sv
// ---------------------------------------------------------------------------
// edge_event_monitor
//
// Multi-channel edge/event monitor. Each channel watches one synchronous
// signal and, depending on its 2-bit mode, reports rising, falling or both
// edges. For every channel the block keeps:
//   - a one-cycle registered event pulse (latency 1 from the sampled edge),
//   - a sticky "edge seen" flag,
//   - a saturating event counter with a sticky overflow flag,
//   - a no-activity watchdog with a sticky timeout flag.
// All flags are combined, under per-channel enables, into one interrupt.
//
// Parameters:
//   NUM_CH  - number of monitored channels (1..32)
//   CNT_W   - event counter width per channel (2..16)
//   TIMEOUT - idle cycles before the watchdog flag sets (1..65535)
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst          asynchronous active-high reset
//   i_sig          monitored signals, synchronous to i_clk
//   i_mode         per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both
//   i_clr          per-channel clear pulse
//   i_irq_en       per-channel interrupt enable
//   o_edge_pulse   one-cycle qualifying-edge pulse
//   o_sticky       latched edge-seen flag
//   o_count        saturating counts, channel i at [CNT_W*i +: CNT_W]
//   o_ovf          sticky counter-saturation flag
//   o_timeout      sticky watchdog flag
//   o_irq          interrupt
// ---------------------------------------------------------------------------
module edge_event_monitor #(
    parameter int NUM_CH  = 4,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic [NUM_CH-1:0]         i_sig,
    input  logic [2*NUM_CH-1:0]       i_mode,
    input  logic [NUM_CH-1:0]         i_clr,
    input  logic [NUM_CH-1:0]         i_irq_en,
    output logic [NUM_CH-1:0]         o_edge_pulse,
    output logic [NUM_CH-1:0]         o_sticky,
    output logic [CNT_W*NUM_CH-1:0]   o_count,
    output logic [NUM_CH-1:0]         o_ovf,
    output logic [NUM_CH-1:0]         o_timeout,
    output logic                      o_irq
);

    // Watchdog counter just wide enough to hold TIMEOUT itself.
    localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0]  WD_MAX  = WD_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [NUM_CH-1:0] r_prev;
    logic              r_primed;

    // Previous-sample register and the priming bit. The priming bit keeps
    // the very first sample after reset from being compared against the
    // reset value of r_prev, which would otherwise fake an edge.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev   <= '0;
            r_primed <= 1'b0;
        end else begin
            r_prev   <= i_sig;
            r_primed <= 1'b1;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [1:0]       w_mode;
        logic             w_rise;
        logic             w_fall;
        logic             w_qual;
        logic [WD_W-1:0]  w_wdNext;

        logic             r_edgePulse;
        logic             r_sticky;
        logic [CNT_W-1:0] r_count;
        logic             r_ovf;
        logic             r_timeout;
        logic [WD_W-1:0]  r_wd;

        assign w_mode   = i_mode[2*g+1:2*g];
        assign w_rise   = i_sig[g] & ~r_prev[g];
        assign w_fall   = ~i_sig[g] & r_prev[g];
        assign w_wdNext = r_wd + WD_W'(1);

        // Edge qualification uses the mode present at this same clock edge.
        always_comb begin
            w_qual = 1'b0;
            if (r_primed) begin
                unique case (w_mode)
                    2'b01:   w_qual = w_rise;
                    2'b10:   w_qual = w_fall;
                    2'b11:   w_qual = w_rise | w_fall;
                    default: w_qual = 1'b0;
                endcase
            end
        end

        // Per-channel state. The event pulse is emitted even when a clear
        // arrives at the same edge; clear wins for every other piece of
        // state. The watchdog parks at TIMEOUT once it gets there and is
        // frozen at zero while the channel is off, leaving the flag alone.
        always_ff @(posedge i_clk or posedge i_rst) begin
            if (i_rst) begin
                r_edgePulse <= 1'b0;
                r_sticky    <= 1'b0;
                r_count     <= '0;
                r_ovf       <= 1'b0;
                r_timeout   <= 1'b0;
                r_wd        <= '0;
            end else begin
                r_edgePulse <= w_qual;
                if (i_clr[g]) begin
                    r_sticky  <= 1'b0;
                    r_count   <= '0;
                    r_ovf     <= 1'b0;
                    r_timeout <= 1'b0;
                    r_wd      <= '0;
                end else begin
                    if (w_qual) begin
                        r_sticky <= 1'b1;
                        if (r_count == CNT_MAX) begin
                            r_ovf <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    if (w_mode == 2'b00) begin
                        r_wd <= '0;
                    end else if (w_qual) begin
                        r_wd <= '0;
                    end else if (r_wd != WD_MAX) begin
                        r_wd <= w_wdNext;
                        if (w_wdNext == WD_MAX) begin
                            r_timeout <= 1'b1;
                        end
                    end
                end
            end
        end

        assign o_edge_pulse[g]            = r_edgePulse;
        assign o_sticky[g]                = r_sticky;
        assign o_count[CNT_W*g +: CNT_W]  = r_count;
        assign o_ovf[g]                   = r_ovf;
        assign o_timeout[g]               = r_timeout;
    end

    // Interrupt is a pure function of registered flags and the enables, so
    // it carries no combinational path from the monitored signals.
    assign o_irq = |(i_irq_en & (o_sticky | o_timeout | o_ovf));

endmodule

// File: tb/tb_edge_event_monitor.sv
// ---------------------------------------------------------------------------
// tb_edge_event_monitor
//
// Directed bench for edge_event_monitor with the default parameters
// (4 channels, 8-bit counters, watchdog of 16 cycles). Inputs are driven
// 1 time unit after each rising clock edge and outputs are inspected at the
// same point, so every observation reflects the edge just taken.
// ---------------------------------------------------------------------------
module tb_edge_event_monitor;

    logic        clk;
    logic        rst;
    logic [3:0]  sig;
    logic [7:0]  mode;
    logic [3:0]  clr;
    logic [3:0]  irqEn;
    logic [3:0]  edgePulse;
    logic [3:0]  sticky;
    logic [31:0] count;
    logic [3:0]  ovf;
    logic [3:0]  timeoutFlag;
    logic        irq;

    int checkCount = 0;
    int passCount  = 0;

    edge_event_monitor #(
        .NUM_CH (4),
        .CNT_W  (8),
        .TIMEOUT(16)
    ) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_sig       (sig),
        .i_mode      (mode),
        .i_clr       (clr),
        .i_irq_en    (irqEn),
        .o_edge_pulse(edgePulse),
        .o_sticky    (sticky),
        .o_count     (count),
        .o_ovf       (ovf),
        .o_timeout   (timeoutFlag),
        .o_irq       (irq)
    );

    // Free-running clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive every functional input and take one clock edge.
    task automatic applyStimulus(input logic [3:0] s, input logic [7:0] m,
                                 input logic [3:0] c, input logic [3:0] e);
        sig   = s;
        mode  = m;
        clr   = c;
        irqEn = e;
        tick();
    endtask

    // One comparison: counts it, and reports observed/expected on failure.
    task automatic checkOutput(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] chCount(input int ch);
        return 32'(count[8*ch +: 8]);
    endfunction

    initial begin
        // ---- Reset with all signals high, then release and hold ----------
        rst   = 1'b1;
        sig   = 4'hF;
        mode  = 8'hFF;
        clr   = 4'h0;
        irqEn = 4'hF;
        tick();
        tick();
        checkOutput("reset_edge",    32'(edgePulse),   32'h0);
        checkOutput("reset_count",   count,            32'h0);
        checkOutput("reset_sticky",  32'(sticky),      32'h0);
        checkOutput("reset_ovf",     32'(ovf),         32'h0);
        checkOutput("reset_timeout", 32'(timeoutFlag), 32'h0);
        checkOutput("reset_irq",     32'(irq),         32'h0);
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("prime_edge", 32'(edgePulse), 32'h0);
        end
        checkOutput("prime_count",  count,       32'h0);
        checkOutput("prime_sticky", 32'(sticky), 32'h0);

        // ---- ch0 rise mode: 0,1,0,1 gives two pulses ---------------------
        applyStimulus(4'hF, 8'b00_00_00_01, 4'hF, 4'h0);
        applyStimulus(4'hE, 8'b00_00_00_01, 4'h0, 4'h0);
        checkOutput("ch0_fall_ignored", 32'(edgePulse), 32'h0);
        applyStimulus(4'hF, 8'b00_00_00_01, 4'h0, 4'h0);
        checkOutput("ch0_rise1_pulse", 32'(edgePulse), 32'h1);
        checkOutput("ch0_rise1_count", chCount(0),     32'd1);
        applyStimulus(4'hE, 8'b00_00_00_01, 4'h0, 4'h0);
        checkOutput("ch0_pulse_drop",  32'(edgePulse), 32'h0);
        applyStimulus(4'hF, 8'b00_00_00_01, 4'h0, 4'h0);
        checkOutput("ch0_rise2_pulse", 32'(edgePulse), 32'h1);
        checkOutput("ch0_rise2_count", chCount(0),     32'd2);
        checkOutput("ch0_sticky",      32'(sticky),    32'h1);
        checkOutput("ch0_irq_masked",  32'(irq),       32'h0);
        irqEn = 4'h1;
        #1;
        checkOutput("ch0_irq", 32'(irq), 32'h1);
        applyStimulus(4'hF, 8'b00_00_00_01, 4'h0, 4'h1);
        checkOutput("ch0_idle_pulse", 32'(edgePulse), 32'h0);

        // ---- ch1 both-edge mode, 300 toggles, saturates at 255 -----------
        mode = 8'b00_00_11_01;
        for (int k = 1; k <= 300; k++) begin
            sig[1] = ~sig[1];
            tick();
            if (k == 255) begin
                checkOutput("ch1_count_255", chCount(1),    32'd255);
                checkOutput("ch1_ovf_before", 32'(ovf[1]), 32'h0);
            end
            if (k == 256) begin
                checkOutput("ch1_count_hold", chCount(1),  32'd255);
                checkOutput("ch1_ovf_set",    32'(ovf[1]), 32'h1);
            end
        end
        checkOutput("ch1_count_final", chCount(1),        32'd255);
        checkOutput("ch1_ovf_final",   32'(ovf[1]),       32'h1);
        checkOutput("ch1_b2b_pulse",   32'(edgePulse[1]), 32'h1);

        // ---- ch2 fall mode watchdog -------------------------------------
        applyStimulus(4'hF, 8'b00_10_00_00, 4'h4, 4'h4);
        clr = 4'h0;
        for (int k = 0; k < 15; k++) tick();
        checkOutput("ch2_timeout_early", 32'(timeoutFlag[2]), 32'h0);
        checkOutput("ch2_irq_early",     32'(irq),            32'h0);
        tick();
        checkOutput("ch2_timeout_set", 32'(timeoutFlag[2]), 32'h1);
        checkOutput("ch2_irq_timeout", 32'(irq),            32'h1);
        applyStimulus(4'hB, 8'b00_10_00_00, 4'h0, 4'h4);
        checkOutput("ch2_fall_pulse",    32'(edgePulse[2]),   32'h1);
        checkOutput("ch2_fall_count",    chCount(2),          32'd1);
        checkOutput("ch2_timeout_kept",  32'(timeoutFlag[2]), 32'h1);
        applyStimulus(4'hB, 8'b00_10_00_00, 4'h4, 4'h4);
        checkOutput("ch2_clr_timeout", 32'(timeoutFlag[2]), 32'h0);
        checkOutput("ch2_clr_sticky",  32'(sticky[2]),      32'h0);
        checkOutput("ch2_clr_count",   chCount(2),          32'd0);
        checkOutput("ch2_clr_irq",     32'(irq),            32'h0);

        // ---- ch3 clear and rise at the same edge -------------------------
        applyStimulus(4'h3, 8'b01_00_00_00, 4'h0, 4'h0);
        applyStimulus(4'hB, 8'b01_00_00_00, 4'h8, 4'h0);
        checkOutput("ch3_clr_pulse",  32'(edgePulse[3]), 32'h1);
        checkOutput("ch3_clr_count",  chCount(3),        32'd0);
        checkOutput("ch3_clr_sticky", 32'(sticky[3]),    32'h0);
        applyStimulus(4'h3, 8'b01_00_00_00, 4'h0, 4'h0);
        checkOutput("ch3_pulse_drop", 32'(edgePulse[3]), 32'h0);
        applyStimulus(4'hB, 8'b01_00_00_00, 4'h0, 4'h0);
        checkOutput("ch3_rise_count",  chCount(3),     32'd1);
        checkOutput("ch3_rise_sticky", 32'(sticky[3]), 32'h1);

        // ---- async reset mid-stream with count0=5 ------------------------
        applyStimulus(4'hB, 8'b00_00_00_01, 4'h1, 4'h1);
        clr = 4'h0;
        for (int k = 0; k < 5; k++) begin
            sig[0] = 1'b0;
            tick();
            sig[0] = 1'b1;
            tick();
        end
        checkOutput("ch0_count_5",   chCount(0), 32'd5);
        checkOutput("ch0_irq_pre",   32'(irq),   32'h1);
        rst = 1'b1;
        #2;
        checkOutput("async_count",   count,            32'h0);
        checkOutput("async_sticky",  32'(sticky),      32'h0);
        checkOutput("async_ovf",     32'(ovf),         32'h0);
        checkOutput("async_timeout", 32'(timeoutFlag), 32'h0);
        checkOutput("async_irq",     32'(irq),         32'h0);
        tick();
        rst = 1'b0;
        tick();
        checkOutput("reprime_edge",  32'(edgePulse), 32'h0);
        checkOutput("reprime_count", chCount(0),     32'd0);
        sig[0] = 1'b0;
        tick();
        sig[0] = 1'b1;
        tick();
        checkOutput("resume_pulse", 32'(edgePulse[0]), 32'h1);
        checkOutput("resume_count", chCount(0),        32'd1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/edge_event_monitor.md
Name: edge_event_monitor

Overview:
- Parametrised multi-channel edge/event monitor. Successor to our single-signal rising-edge check.
- Per channel: selectable rise/fall/both detection, one-cycle event pulse, saturating event counter, sticky flag, and a no-activity watchdog.
- Sits beside DUT-facing control signals in testbenches and in RTL status blocks; feeds a single interrupt line.

Parameters:
- NUM_CH, 4: number of monitored channels (1..32).
- CNT_W, 8: event counter width per channel (2..16).
- TIMEOUT, 16: cycles without a qualifying edge before the watchdog flag sets (1..2^16-1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  asynchronous, active-high reset.
- sig  input  NUM_CH  monitored signals, already synchronous to clk.
- mode  input  2*NUM_CH  per channel [2i+1:2i]: 00 off, 01 rise, 10 fall, 11 both.
- clr  input  NUM_CH  per-channel clear pulse.
- irq_en  input  NUM_CH  per-channel interrupt enable.
- edge_pulse  output  NUM_CH  one-cycle qualifying-edge pulse.
- sticky  output  NUM_CH  latched "edge seen" flag.
- count  output  CNT_W*NUM_CH  per-channel saturating event count, channel i at [CNT_W*i +: CNT_W].
- ovf  output  NUM_CH  sticky counter-saturation flag.
- timeout  output  NUM_CH  sticky watchdog flag.
- irq  output  1  interrupt.

Behaviour:
- Reset (async assert, sync release): prev, primed, edge_pulse, sticky, count, ovf, timeout and watchdog counters are all 0; irq=0.
- Sampling: each posedge registers sig into prev. primed sets on the first posedge after reset release. No edge is detected on that first sample, so there is no spurious rise when sig=1 out of reset.
- Detection at posedge, primed=1:
  - rise = sig & ~prev; fall = ~sig & prev.
  - Qualifying edge per mode. Mode 00 never qualifies.
  - The mode value sampled at that same posedge applies; mode changes take effect immediately and carry no history.
- edge_pulse[i] is registered: high for exactly one cycle following the posedge where the edge was sampled (latency 1). Back-to-back toggles give back-to-back pulses.
- sticky[i] sets on a qualifying edge and holds until clr[i].
- count[i] increments by 1 per qualifying edge.
  - If count is already all-ones, it holds and ovf[i] sets (sticky).
  - Wrap-around is never allowed.
- Watchdog, per channel, mode!=00:
  - The counter increments each cycle and resets to 0 on a qualifying edge or clr.
  - When it reaches TIMEOUT, timeout[i] sets and the counter holds.
  - Mode 00: the watchdog counter is held at 0; timeout retains its value.
- clr[i] clears sticky, count, ovf, timeout and the watchdog for channel i in the next cycle.
  - clr and a qualifying edge at the same posedge: clr wins for sticky/count/ovf/timeout (all 0).
  - edge_pulse is still emitted.
- irq = |(irq_en & (sticky | timeout | ovf)). Combinational from registers only, glitch-free. Deasserts one cycle after the clearing clr.
- Reset mid-operation: all state clears immediately (async). The primed rule applies again after release.
- Channels are fully independent; simultaneous edges on all channels are each counted.

Test Plan:
- Reset with sig=4'b1111, release, hold for 3 cycles -> no edge_pulse, count all 0, sticky 0.
- ch0 mode=01, sig[0] 0->1->0->1 on successive cycles -> 2 edge_pulses, each 1 cycle after the sampled rise; count0=2; sticky0=1; irq=1 when irq_en[0]=1.
- ch1 mode=11, toggle every cycle for 300 cycles with CNT_W=8 -> count1 holds at 255, ovf1=1, no wrap to 0.
- ch2 mode=10, no edges -> timeout2 sets exactly 16 cycles after the last clr. Then a falling edge does not clear timeout2; clr2 does.
- clr3 asserted on the same posedge as a ch3 rise -> edge_pulse3=1, count3=0, sticky3=0.
- Assert rst mid-stream with count0=5 -> all outputs 0 asynchronously, without waiting for clk; counting resumes from 0 after the priming sample.
